// File: rtl/dram_seq_pkg.sv
// dram_seq_pkg: shared state encoding, bank codes and counter sizing for the DRAM sequencer.
package dram_seq_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_RAS, ST_MUXW, ST_CAS, ST_REF, ST_PRE} state_t;
    localparam logic BANK1 = 1'b0;
    localparam logic BANK2 = 1'b1;
    localparam int CNT_W = 3;
endpackage

// File: rtl/dram_seq_sync_bit.sv
// sync_bit: flop-chain synchroniser for one asynchronous Z80 strobe, preset to inactive (1).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) sync_q <= '1;
        else       sync_q <= sync_d;

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/dram_sequencer.sv
// dram_sequencer: single-clock RAS/CAS/MUX generator for Z80 DRAM access and RAS-only refresh,
// with 8-bit refresh row extension on RAMA7 and a sticky refresh-timeout flag.
module dram_sequencer
    import dram_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int T_RM        = 1,
    parameter int T_MC        = 1,
    parameter int T_PRE       = 2,
    parameter int REF_TIMEOUT = 4096
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic MREQ,
    input  logic RD,
    input  logic WR,
    input  logic RFSH,
    input  logic A6,
    input  logic A7,
    input  logic A14,
    input  logic A15,
    output logic RAS1,
    output logic RAS2,
    output logic CAS1,
    output logic CAS2,
    output logic MUX,
    output logic RAMA7,
    output logic REFTO
);
    localparam int RT_W = $clog2(REF_TIMEOUT + 1);

    logic mreq_s, rd_s, wr_s, rfsh_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_mreq (.CLK(CLK), .RSTN(RSTN), .d(MREQ), .q(mreq_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rd   (.CLK(CLK), .RSTN(RSTN), .d(RD),   .q(rd_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wr   (.CLK(CLK), .RSTN(RSTN), .d(WR),   .q(wr_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rfsh (.CLK(CLK), .RSTN(RSTN), .d(RFSH), .q(rfsh_s));

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic bank_q, bank_d, r7_q, r7_d, a6_prev_q, a6_prev_d;
    logic ras1_q, ras1_d, ras2_q, ras2_d, cas1_q, cas1_d, cas2_q, cas2_d;
    logic mux_q, mux_d, rama7_q, rama7_d, refto_q, refto_d;
    logic in_access;

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        r7_d      = r7_q;
        a6_prev_d = a6_prev_q;
        rama7_d   = rama7_q;
        case (state_q)
            ST_IDLE:
                if (!mreq_s && !rfsh_s) begin
                    state_d   = ST_REF;
                    a6_prev_d = A6;
                    // A6 falling between refreshes means the 7-bit row counter wrapped
                    r7_d      = r7_q ^ (a6_prev_q & ~A6);
                    rama7_d   = r7_d;
                end else if (!mreq_s && (!rd_s || !wr_s) && A15) begin
                    state_d = ST_RAS;
                    bank_d  = A14;
                    rama7_d = A7;
                end
            ST_RAS:  state_d = mreq_s ? ST_PRE : (cnt_q == CNT_W'(T_RM - 1)) ? ST_MUXW : ST_RAS;
            ST_MUXW: state_d = mreq_s ? ST_PRE : (cnt_q == CNT_W'(T_MC - 1)) ? ST_CAS : ST_MUXW;
            ST_CAS:  state_d = mreq_s ? ST_PRE : ST_CAS;
            ST_REF:  state_d = mreq_s ? ST_PRE : ST_REF;
            ST_PRE:  state_d = (cnt_q == CNT_W'(T_PRE - 1)) ? ST_IDLE : ST_PRE;
            default: state_d = ST_IDLE;
        endcase
        cnt_d     = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        in_access = (state_d == ST_RAS) || (state_d == ST_MUXW) || (state_d == ST_CAS);
        ras1_d    = !((state_d == ST_REF) || (in_access && bank_d == BANK1));
        ras2_d    = !((state_d == ST_REF) || (in_access && bank_d == BANK2));
        cas1_d    = !(state_d == ST_CAS && bank_d == BANK1);
        cas2_d    = !(state_d == ST_CAS && bank_d == BANK2);
        mux_d     = (state_d == ST_MUXW) || (state_d == ST_CAS);
        ref_cnt_d = (state_d == ST_REF && state_q != ST_REF) ? '0 :
                    (ref_cnt_q == RT_W'(REF_TIMEOUT)) ? ref_cnt_q : ref_cnt_q + 1'b1;
        refto_d   = refto_q | (ref_cnt_d == RT_W'(REF_TIMEOUT));
    end

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            bank_q    <= BANK1;
            r7_q      <= 1'b0;
            a6_prev_q <= 1'b0;
            ras1_q    <= 1'b1;
            ras2_q    <= 1'b1;
            cas1_q    <= 1'b1;
            cas2_q    <= 1'b1;
            mux_q     <= 1'b0;
            rama7_q   <= 1'b0;
            refto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_cnt_q <= ref_cnt_d;
            bank_q    <= bank_d;
            r7_q      <= r7_d;
            a6_prev_q <= a6_prev_d;
            ras1_q    <= ras1_d;
            ras2_q    <= ras2_d;
            cas1_q    <= cas1_d;
            cas2_q    <= cas2_d;
            mux_q     <= mux_d;
            rama7_q   <= rama7_d;
            refto_q   <= refto_d;
        end

    assign RAS1  = ras1_q;
    assign RAS2  = ras2_q;
    assign CAS1  = cas1_q;
    assign CAS2  = cas2_q;
    assign MUX   = mux_q;
    assign RAMA7 = rama7_q;
    assign REFTO = refto_q;
endmodule
